fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly downstream of the next-PC calculation; it consumes the redirect address/enable pair that the calculation produces.
- Holds the architectural fetch PC and issues sequential requests to instruction memory over a valid/ready request and valid-only response interface.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- On redirect, flushes the buffer and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC of first fetch after reset
IBUF_DEPTH, 2, instruction FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
redirect_addr  input  32  new fetch PC from next-PC calculation
redirect_en  input  1  redirect_addr valid this cycle
imem_req_valid  output  1  memory request valid (registered)
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  request address, word aligned
imem_rsp_valid  input  1  response data valid, one per accepted request, in order
imem_rsp_data  input  32  instruction word
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decode consumes head
inst_pc  output  32  PC of head instruction
inst_data  output  32  head instruction word

Behaviour:
- Reset (async assert): pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=0, FIFO empty (inst_valid=0, inst_pc=0, inst_data=0), stale=0. Reset mid-operation abandons any outstanding request. The bench must not drive imem_rsp_valid for an abandoned request.
- At most one request outstanding. State machine:
  - IDLE: if launch condition holds, then imem_req_valid<=1, imem_req_addr<=pc, go REQ.
  - REQ: imem_req_valid/addr held stable until imem_req_ready. On acceptance: imem_req_valid<=0, pc<=pc+4 (unless redirected), go WAIT.
  - WAIT: on imem_rsp_valid, push {req_addr, rsp_data} unless stale, then clear stale. If launch condition holds, go directly to REQ (back-to-back), else IDLE.
- Launch condition: FIFO occupancy after this cycle's push/pop < IDLE_DEPTH, with no redirect this cycle.
- First imem_req_valid rises on the first clock edge after reset_n deasserts (FIFO empty).
- Latency: response to inst_valid is 1 cycle (registered push); inst_valid is FIFO non-empty.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. redirect_addr[1:0] is ignored (forced 0).
- FIFO:
  - Push on non-stale response; pop on inst_valid && inst_ready.
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - The launch condition guarantees no push when full without a pop.
- Redirect (redirect_en=1) takes priority over everything else that cycle:
  - FIFO flushed; a same-cycle pop is ignored and a same-cycle push is dropped. inst_valid=0 next cycle.
  - pc<=redirect_addr.
  - IDLE: go IDLE; the next request issues the following cycle with redirect_addr.
  - REQ and not accepted this cycle: request stays held (address unchanged, AXI-style stability) and stale<=1.
  - REQ and accepted this cycle: go WAIT with stale<=1; pc is not incremented.
  - WAIT with no response this cycle: stale<=1.
  - WAIT with a response this cycle: response dropped, stale stays 0, go IDLE.
- Back-to-back redirects: the latest redirect_addr wins; stale remains 1 (single outstanding).
- A response while stale=1 is dropped; after the drop the state returns to IDLE or REQ and fetches from pc.
- imem_rsp_valid outside WAIT is a protocol error and is ignored.

Test Plan:
- Reset release, RESET_PC=0x100, memory ready=1, 1-cycle response, inst_ready=1 -> requests 0x100,0x104,0x108 in order; inst_pc/inst_data match each in order, one instruction per 2 cycles steady state.
- inst_ready=0, IBUF_DEPTH=2 -> exactly 2 instructions buffered (0x100,0x104), no third request issued; raise inst_ready -> fetch resumes at 0x108 with no loss or duplication.
- Redirect to 0x2000 while in WAIT for 0x104 -> 0x104 response dropped, FIFO empty next cycle, next request address 0x2000, next inst_pc 0x2000.
- imem_req_ready=0 for 3 cycles, redirect to 0x400 in cycle 2 -> imem_req_addr held at old value until accepted; its response is dropped; following request is 0x400.
- Redirect and inst_ready pop in the same cycle with 2 entries buffered -> both entries flushed, inst_valid=0 next cycle, no entry delivered.
- Assert reset_n low during REQ -> imem_req_valid and inst_valid go 0 immediately; after release the first request is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, issues single-outstanding memory
// requests and buffers returned words with their PCs for decode.
//
// state  | meaning
// IDLE   | no request in flight, waiting for buffer room
// REQ    | request presented, held stable until accepted
// WAIT   | request accepted, waiting for its response
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] redirect_addr,
  input  logic        redirect_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);
  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
  localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic          r_stale;
  logic          r_req_valid;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_buf_pc   [IBUF_DEPTH];
  logic [31:0]   r_buf_data [IBUF_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_launch;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_redir_pc;

  assign w_redir_pc  = redirect_addr & ~32'd3;
  assign w_push      = (r_state == S_WAIT) && imem_rsp_valid && !r_stale && !redirect_en;
  assign w_pop       = inst_valid && inst_ready && !redirect_en;
  assign w_count_nxt = redirect_en ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  // Launching only below full leaves room for the single response in flight.
  assign w_launch    = !redirect_en && (w_count_nxt < DEPTH_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC_W;
      r_stale     <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_pc;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT;
            // A stale held request was not fetched from r_pc, so r_pc stays put.
            if (!redirect_en && !r_stale) r_pc <= r_pc + 32'd4;
          end
          if (redirect_en) r_stale <= 1'b1;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_stale <= 1'b0;
            if (w_launch) begin
              r_req_valid <= 1'b1;
              r_req_addr  <= r_pc;
              r_state     <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (redirect_en) begin
            r_stale <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
      if (redirect_en) r_pc <= w_redir_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_en) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= r_req_addr;
      r_buf_data[r_wr_ptr] <= imem_rsp_data;
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = (r_count != '0);
  assign inst_pc        = inst_valid ? r_buf_pc[r_rd_ptr]   : '0;
  assign inst_data      = inst_valid ? r_buf_data[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked against a
// transaction-level model of the fetch stream (expected PC, delivery queue).
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        redirect_en = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_addr(redirect_addr), .redirect_en(redirect_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference model: next expected fetch PC, delivery queue, outstanding request.
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_req_stale;
  bit          out_v;
  bit          out_stale;
  logic [31:0] out_addr;
  int          out_cnt;
  int          max_delay = 1;
  bit          hold_prev;
  logic [31:0] hold_addr;
  logic [31:0] fire_log[$];
  int          pop_cyc[$];
  int          pops = 0;
  logic [31:0] last_pop_pc;
  int          cyc = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc        = RPC;
    m_req_stale = 1'b0;
    out_v       = 1'b0;
    out_stale   = 1'b0;
    out_cnt     = 0;
    hold_prev   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_en    = 1'b0;
    redirect_addr  = '0;
    inst_ready     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fire_log.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rdy, input bit ir, input bit redir, input logic [31:0] raddr);
    bit   rsp;
    bit   fire;
    bit   pop;
    ent_t e;
    check("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    if (hold_prev) begin
      check("req_hold_valid", 32'(imem_req_valid), 32'd1);
      check("req_hold_addr", imem_req_addr, hold_addr);
    end
    imem_req_ready = rdy;
    inst_ready     = ir;
    redirect_en    = redir;
    redirect_addr  = raddr;
    rsp = 1'b0;
    if (out_v) begin
      if (out_cnt == 0) rsp = 1'b1;
      else out_cnt--;
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memfn(out_addr) : $urandom;
    fire = imem_req_valid && rdy;
    pop  = inst_valid && ir && !redir;
    if (pop && q.size() != 0) begin
      e = q.pop_front();
      check("inst_pc", inst_pc, e.pc);
      check("inst_data", inst_data, e.data);
      pops++;
      last_pop_pc = e.pc;
      pop_cyc.push_back(cyc);
    end
    if (rsp) begin
      if (!out_stale && !redir) begin
        e.pc   = out_addr;
        e.data = memfn(out_addr);
        q.push_back(e);
      end
      out_v = 1'b0;
    end
    if (fire) begin
      fire_log.push_back(imem_req_addr);
      if (!m_req_stale) begin
        check("req_addr", imem_req_addr, m_pc);
        if (!redir) m_pc = m_pc + 32'd4;
      end
      out_v       = 1'b1;
      out_addr    = imem_req_addr;
      out_stale   = m_req_stale || redir;
      out_cnt     = $urandom_range(max_delay - 1, 0);
      m_req_stale = 1'b0;
    end else if (redir && imem_req_valid) begin
      m_req_stale = 1'b1;
    end
    if (redir) begin
      q.delete();
      m_pc = raddr & ~32'd3;
      if (out_v && !fire) out_stale = 1'b1;
    end
    hold_prev = imem_req_valid && !rdy;
    hold_addr = imem_req_addr;
    check("occ_bound", 32'((q.size() + int'(out_v && !out_stale)) <= DEPTH), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    model_reset();
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);

    // Streaming: sequential fetch, one instruction per two cycles.
    do_reset();
    pop_cyc.delete();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("t1_fire0", fire_log[0], 32'h100);
    check("t1_fire1", fire_log[1], 32'h104);
    check("t1_fire2", fire_log[2], 32'h108);
    check("t1_rate", 32'(pop_cyc[3] - pop_cyc[2]), 32'd2);

    // Decode stalled: buffer fills to depth, then fetch resumes.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("t2_fires", 32'(fire_log.size()), 32'd2);
    check("t2_fill", 32'(q.size()), 32'd2);
    n = 0;
    while (fire_log.size() < 3 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t2_resume", fire_log[2], 32'h108);

    // Redirect on the response cycle of 0x104.
    do_reset();
    n = 0;
    while (fire_log.size() < 2 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t3_fire1", fire_log[1], 32'h104);
    step(1'b1, 1'b1, 1'b1, 32'h2000);
    check("t3_flushed", 32'(inst_valid), 32'd0);
    n = 0;
    while (fire_log.size() < 3 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t3_new_req", fire_log[2], 32'h2000);
    p0 = pops; n = 0;
    while (pops == p0 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t3_new_pc", last_pop_pc, 32'h2000);

    // Request held while not ready; redirect during the hold.
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h400);
    step(1'b0, 1'b1, 1'b0, '0);
    check("t4_held", imem_req_addr, 32'h100);
    n = 0;
    while (fire_log.size() < 2 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t4_stale_fire", fire_log[0], 32'h100);
    check("t4_next_req", fire_log[1], 32'h400);

    // Redirect together with a pop while two entries are buffered.
    do_reset();
    n = 0;
    while (!(q.size() == 2 && !out_v) && n < 30) begin step(1'b1, 1'b0, 1'b0, '0); n++; end
    check("t5_fill", 32'(q.size()), 32'd2);
    step(1'b0, 1'b1, 1'b1, 32'h3000);
    check("t5_valid", 32'(inst_valid), 32'd0);
    check("t5_data", inst_data, 32'd0);
    p0 = pops; n = 0;
    while (pops == p0 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t5_next_pc", last_pop_pc, 32'h3000);

    // Asynchronous reset while a request is pending.
    do_reset();
    n = 0;
    while (!(q.size() == 1 && imem_req_valid) && n < 20) begin step(1'b0, 1'b0, 1'b0, '0); step(1'b1, 1'b0, 1'b0, '0); n++; end
    check("t6_pre_valid", 32'(inst_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_req_addr", imem_req_addr, 32'd0);
    do_reset();
    n = 0;
    while (fire_log.size() < 1 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t6_first_req", fire_log[0], RPC);

    // PC wrap and low-bit masking of the redirect address.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD);
    n = 0;
    while (fire_log.size() < 2 && n < 20) begin step(1'b1, 1'b1, 1'b0, '0); n++; end
    check("t7_top", fire_log[0], 32'hFFFF_FFFC);
    check("t7_wrap", fire_log[1], 32'h0000_0000);

    // Random traffic.
    max_delay = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6, $urandom_range(99, 0) < 5, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
